// File: rtl/vram_port_arbiter_if.sv
// rtl/vram_port_arbiter_if.sv - display, client and memory signal bundle for vram_port_arbiter
interface vram_port_arbiter_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 12
);
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic [DATA_W-1:0] disp_data;
    logic              disp_dvalid;

    logic              cl_valid;
    logic              cl_ready;
    logic              cl_we;
    logic [ADDR_W-1:0] cl_addr;
    logic [DATA_W-1:0] cl_wdata;
    logic [DATA_W-1:0] cl_rdata;
    logic              cl_rvalid;
    logic [15:0]       cl_wait_max;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    modport slave (
        input  disp_req, disp_addr, cl_valid, cl_we, cl_addr, cl_wdata, mem_dout,
        output disp_data, disp_dvalid, cl_ready, cl_rdata, cl_rvalid, cl_wait_max,
        output mem_en, mem_we, mem_addr, mem_din
    );

    modport master (
        output disp_req, disp_addr, cl_valid, cl_we, cl_addr, cl_wdata, mem_dout,
        input  disp_data, disp_dvalid, cl_ready, cl_rdata, cl_rvalid, cl_wait_max,
        input  mem_en, mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/vram_port_arbiter.sv
// rtl/vram_port_arbiter.sv - shares one image memory port: display reads first, posted client writes, then client reads
module vram_port_arbiter #(
    parameter int ADDR_W      = 17,
    parameter int DATA_W      = 12,
    parameter int RD_LAT      = 1,
    parameter int WFIFO_DEPTH = 4
) (
    input logic                clk,
    input logic                rst,
    vram_port_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(WFIFO_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    typedef enum logic [1:0] {
        GNT_IDLE,
        GNT_DISP,
        GNT_WRITE,
        GNT_CLREAD
    } grant_e;

    logic [ADDR_W-1:0] wf_addr_q [WFIFO_DEPTH];
    logic [DATA_W-1:0] wf_data_q [WFIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic              wf_empty, wf_full;
    logic              push, pop;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic              cl_ready;
    grant_e            grant;

    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_din_q, mem_din_d;

    // One entry per cycle of read latency plus the issue register stage.
    logic [RD_LAT:0]   tag_vld_q, tag_vld_d;
    logic [RD_LAT:0]   tag_cl_q, tag_cl_d;
    logic              disp_hit, cl_hit;

    logic [15:0]       wait_cnt_q, wait_cnt_d;
    logic [15:0]       wait_max_q, wait_max_d;

    assign wf_empty  = (wr_ptr_q == rd_ptr_q);
    assign wf_full   = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                       (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    assign head_addr = wf_addr_q[rd_ptr_q[IDX_W-1:0]];
    assign head_data = wf_data_q[rd_ptr_q[IDX_W-1:0]];

    // Reads wait for an empty FIFO so they always observe earlier posted writes.
    assign cl_ready = bus.cl_we ? !wf_full : (!bus.disp_req && wf_empty);
    assign push     = bus.cl_valid && bus.cl_we && !wf_full;
    assign pop      = (grant == GNT_WRITE);

    always_comb begin
        grant = GNT_IDLE;
        if (bus.disp_req) begin
            grant = GNT_DISP;
        end else if (!wf_empty) begin
            grant = GNT_WRITE;
        end else if (bus.cl_valid && !bus.cl_we) begin
            grant = GNT_CLREAD;
        end
    end

    always_comb begin
        mem_en_d   = (grant != GNT_IDLE);
        mem_we_d   = (grant == GNT_WRITE);
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        tag_vld_d  = {tag_vld_q[RD_LAT-1:0], 1'b0};
        tag_cl_d   = {tag_cl_q[RD_LAT-1:0], 1'b0};
        case (grant)
            GNT_DISP: begin
                mem_addr_d   = bus.disp_addr;
                tag_vld_d[0] = 1'b1;
            end
            GNT_WRITE: begin
                mem_addr_d = head_addr;
                mem_din_d  = head_data;
            end
            GNT_CLREAD: begin
                mem_addr_d   = bus.cl_addr;
                tag_vld_d[0] = 1'b1;
                tag_cl_d[0]  = 1'b1;
            end
            default: begin
            end
        endcase

        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);

        wait_cnt_d = wait_cnt_q;
        if (bus.cl_valid && cl_ready) begin
            wait_cnt_d = '0;
        end else if (bus.cl_valid && (wait_cnt_q != 16'hFFFF)) begin
            wait_cnt_d = wait_cnt_q + 16'd1;
        end
        wait_max_d = (wait_cnt_q > wait_max_q) ? wait_cnt_q : wait_max_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            tag_vld_q  <= '0;
            tag_cl_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            wait_cnt_q <= '0;
            wait_max_q <= '0;
        end else begin
            mem_en_q   <= mem_en_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            tag_vld_q  <= tag_vld_d;
            tag_cl_q   <= tag_cl_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            wait_cnt_q <= wait_cnt_d;
            wait_max_q <= wait_max_d;
        end
    end

    // Entry storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            wf_addr_q[wr_ptr_q[IDX_W-1:0]] <= bus.cl_addr;
            wf_data_q[wr_ptr_q[IDX_W-1:0]] <= bus.cl_wdata;
        end
    end

    assign disp_hit = tag_vld_q[RD_LAT] && !tag_cl_q[RD_LAT];
    assign cl_hit   = tag_vld_q[RD_LAT] && tag_cl_q[RD_LAT];

    assign bus.disp_dvalid = disp_hit;
    assign bus.disp_data   = disp_hit ? bus.mem_dout : '0;
    assign bus.cl_rvalid   = cl_hit;
    assign bus.cl_rdata    = cl_hit ? bus.mem_dout : '0;
    assign bus.cl_ready    = cl_ready;
    assign bus.cl_wait_max = wait_max_q;
    assign bus.mem_en      = mem_en_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_din     = mem_din_q;
endmodule

// File: tb/tb_vram_port_arbiter.sv
// tb/tb_vram_port_arbiter.sv - bench for vram_port_arbiter with RD_LAT=1 and RD_LAT=2 instances
module tb_vram_port_arbiter;
    localparam int DEPTH     = 4;
    localparam int MEM_WORDS = 131072;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   k;

    vram_port_arbiter_if #(.ADDR_W(17), .DATA_W(12)) ifa ();
    vram_port_arbiter_if #(.ADDR_W(17), .DATA_W(12)) ifb ();

    vram_port_arbiter #(.RD_LAT(1), .WFIFO_DEPTH(DEPTH)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    vram_port_arbiter #(.RD_LAT(2), .WFIFO_DEPTH(DEPTH)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    assign ifb.disp_req  = ifa.disp_req;
    assign ifb.disp_addr = ifa.disp_addr;
    assign ifb.cl_valid  = ifa.cl_valid;
    assign ifb.cl_we     = ifa.cl_we;
    assign ifb.cl_addr   = ifa.cl_addr;
    assign ifb.cl_wdata  = ifa.cl_wdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port memories, one per latency.
    logic [11:0] mem_a [0:MEM_WORDS-1];
    logic [11:0] mem_b [0:MEM_WORDS-1];
    logic [11:0] rd_a1, rd_b1, rd_b2;
    always @(posedge clk) begin
        if (ifa.mem_en) begin
            if (ifa.mem_we) mem_a[ifa.mem_addr] <= ifa.mem_din;
            else            rd_a1 <= mem_a[ifa.mem_addr];
        end
        if (ifb.mem_en) begin
            if (ifb.mem_we) mem_b[ifb.mem_addr] <= ifb.mem_din;
            else            rd_b1 <= mem_b[ifb.mem_addr];
        end
        rd_b2 <= rd_b1;
    end
    assign ifa.mem_dout = rd_a1;
    assign ifb.mem_dout = rd_b2;

    // Reference model: image contents, posted-write queue, issue history ring.
    logic [11:0] mm [0:MEM_WORDS-1];
    logic [28:0] wq [$];
    logic        m_en [16];
    logic        m_we [16];
    logic        m_rst [16];
    logic [16:0] m_addr [16];
    logic [11:0] m_din [16];
    logic [11:0] m_rdat [16];
    int          m_tag [16];
    int          w_cnt;
    int          w_max;
    logic        exp_rdy;

    logic [11:0] rq_a [$];
    logic [11:0] rq_b [$];
    always @(negedge clk) begin
        if (ifa.cl_rvalid) rq_a.push_back(ifa.cl_rdata);
        if (ifb.cl_rvalid) rq_b.push_back(ifb.cl_rdata);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, k, act, exp);
        end
    endtask

    task automatic cmp_inst(input string p, input int lat, input logic en, input logic we,
                            input logic [16:0] addr, input logic [11:0] din,
                            input logic dv, input logic [11:0] dd, input logic rv,
                            input logic [11:0] rd, input logic rdy, input logic [15:0] wm);
        int e;
        int j;
        e = (k - 1) & 15;
        j = (k - 1 - lat) & 15;
        chk({p, ".mem_en"}, en, m_en[e]);
        chk({p, ".mem_we"}, we, m_we[e]);
        if (m_en[e] || m_rst[e]) chk({p, ".mem_addr"}, addr, m_addr[e]);
        if (m_we[e] || m_rst[e]) chk({p, ".mem_din"}, din, m_din[e]);
        chk({p, ".disp_dvalid"}, dv, m_tag[j] == 1);
        chk({p, ".disp_data"}, dd, (m_tag[j] == 1) ? m_rdat[j] : 12'h0);
        chk({p, ".cl_rvalid"}, rv, m_tag[j] == 2);
        chk({p, ".cl_rdata"}, rd, (m_tag[j] == 2) ? m_rdat[j] : 12'h0);
        chk({p, ".valid_overlap"}, dv & rv, 0);
        if (ifa.cl_valid) chk({p, ".cl_ready"}, rdy, exp_rdy);
        chk({p, ".cl_wait_max"}, wm, w_max);
    endtask

    initial begin
        int e;
        int sz;
        logic [28:0] ent;
        k = 0;
        w_cnt = 0;
        w_max = 0;
        forever begin
            @(negedge clk);
            #1;
            exp_rdy = ifa.cl_we ? (wq.size() < DEPTH) : (!ifa.disp_req && wq.size() == 0);
            if (k >= 3) begin
                cmp_inst("a", 1, ifa.mem_en, ifa.mem_we, ifa.mem_addr, ifa.mem_din, ifa.disp_dvalid,
                         ifa.disp_data, ifa.cl_rvalid, ifa.cl_rdata, ifa.cl_ready, ifa.cl_wait_max);
                cmp_inst("b", 2, ifb.mem_en, ifb.mem_we, ifb.mem_addr, ifb.mem_din, ifb.disp_dvalid,
                         ifb.disp_data, ifb.cl_rvalid, ifb.cl_rdata, ifb.cl_ready, ifb.cl_wait_max);
            end
            e = k & 15;
            m_en[e] = 0; m_we[e] = 0; m_rst[e] = 0; m_addr[e] = 0;
            m_din[e] = 0; m_rdat[e] = 0; m_tag[e] = 0;
            if (rst) begin
                m_rst[e] = 1;
                m_tag[(k - 1) & 15] = 0;
                m_tag[(k - 2) & 15] = 0;
                wq.delete();
                w_cnt = 0;
                w_max = 0;
            end else begin
                sz = wq.size();
                if (w_cnt > w_max) w_max = w_cnt;
                if (ifa.cl_valid && exp_rdy) w_cnt = 0;
                else if (ifa.cl_valid && w_cnt < 65535) w_cnt++;
                if (ifa.disp_req) begin
                    m_en[e] = 1; m_addr[e] = ifa.disp_addr; m_tag[e] = 1; m_rdat[e] = mm[ifa.disp_addr];
                end else if (sz > 0) begin
                    ent = wq.pop_front();
                    m_en[e] = 1; m_we[e] = 1; m_addr[e] = ent[28:12]; m_din[e] = ent[11:0];
                    mm[ent[28:12]] = ent[11:0];
                end else if (ifa.cl_valid && !ifa.cl_we) begin
                    m_en[e] = 1; m_addr[e] = ifa.cl_addr; m_tag[e] = 2; m_rdat[e] = mm[ifa.cl_addr];
                end
                if (ifa.cl_valid && ifa.cl_we && sz < DEPTH) wq.push_back({ifa.cl_addr, ifa.cl_wdata});
            end
            k++;
        end
    end

    // Holds the request until accepted; leaves cl_valid high for the caller to replace or drop.
    task automatic cl_op(input logic we, input logic [16:0] a, input logic [11:0] d, output int waited);
        bit acc;
        acc = 0;
        waited = 0;
        for (int n = 0; n < 2000 && !acc; n++) begin
            @(negedge clk);
            ifa.cl_valid = 1; ifa.cl_we = we; ifa.cl_addr = a; ifa.cl_wdata = d;
            #1;
            acc = ifa.cl_ready;
            if (!acc) waited++;
        end
        chk("cl_op_accept", acc, 1);
    endtask

    task automatic cl_stop();
        @(negedge clk);
        ifa.cl_valid = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired cycle=%0d", k);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int wt [6];
        checks = 0;
        failures = 0;
        for (int i = 0; i < MEM_WORDS; i++) begin
            mm[i] = 12'(i) ^ 12'h5A5;
            mem_a[i] = mm[i];
            mem_b[i] = mm[i];
        end
        rst = 1;
        ifa.disp_req = 0; ifa.disp_addr = '0;
        ifa.cl_valid = 0; ifa.cl_we = 0; ifa.cl_addr = '0; ifa.cl_wdata = '0;
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        #1;
        chk("rst.mem_en", ifa.mem_en, 0);
        chk("rst.mem_addr", ifa.mem_addr, 0);
        chk("rst.mem_din", ifb.mem_din, 0);
        chk("rst.dvalid", ifb.disp_dvalid, 0);
        chk("rst.wait_max", ifa.cl_wait_max, 0);

        // Idle write lands on the memory port two cycles after acceptance.
        cl_op(1, 17'd100, 12'hABC, w);
        chk("idle_wr.wait", w, 0);
        cl_stop();
        @(negedge clk);
        #1;
        chk("idle_wr.a.we", ifa.mem_we, 1);
        chk("idle_wr.a.addr", ifa.mem_addr, 100);
        chk("idle_wr.a.din", ifa.mem_din, 12'hABC);
        chk("idle_wr.b.din", ifb.mem_din, 12'hABC);
        repeat (3) @(negedge clk);

        // Read-after-write to the same address.
        rq_a.delete();
        rq_b.delete();
        cl_op(1, 17'd5, 12'h123, w);
        cl_op(0, 17'd5, 12'h000, w);
        chk("raw.read_held", w, 1);
        cl_stop();
        for (int n = 0; n < 12 && !(rq_a.size() >= 1 && rq_b.size() >= 1); n++) begin
            @(negedge clk);
            #1;
        end
        chk("raw.a.count", rq_a.size(), 1);
        chk("raw.b.count", rq_b.size(), 1);
        if (rq_a.size() >= 1) chk("raw.a.data", rq_a[0], 12'h123);
        if (rq_b.size() >= 1) chk("raw.b.data", rq_b[0], 12'h123);
        repeat (3) @(negedge clk);

        // Display holds the port for 640 cycles while six writes are posted.
        fork
            begin
                for (int i = 0; i < 640; i++) begin
                    @(negedge clk);
                    ifa.disp_req = 1;
                    ifa.disp_addr = 17'(1000 + i);
                end
                @(negedge clk);
                ifa.disp_req = 0;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    #1;
                    chk("drain.we", ifa.mem_we, 1);
                    chk("drain.addr", ifa.mem_addr, 200 + i);
                    chk("drain.din", ifa.mem_din, 12'h700 + i);
                end
            end
            begin
                for (int i = 0; i < 6; i++) cl_op(1, 17'(200 + i), 12'(12'h700 + i), wt[i]);
                cl_stop();
            end
        join
        for (int i = 0; i < 4; i++) chk("disp.first4_wait", wt[i], 0);
        chk("full.w5_wait", wt[4], 637);
        chk("full.w6_wait", wt[5], 0);
        repeat (6) @(negedge clk);
        #1;
        chk("disp.wait_max_ge637", ifa.cl_wait_max >= 16'd637, 1);

        // Alternating display and client reads to addresses 0..3.
        rq_a.delete();
        rq_b.delete();
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    @(negedge clk);
                    ifa.disp_req = (i % 2 == 0);
                    ifa.disp_addr = 17'(300 + i);
                end
                @(negedge clk);
                ifa.disp_req = 0;
            end
            begin
                for (int a = 0; a < 4; a++) cl_op(0, 17'(a), 12'h000, w);
                cl_stop();
            end
        join
        repeat (6) @(negedge clk);
        #1;
        chk("mixed.a.count", rq_a.size(), 4);
        chk("mixed.b.count", rq_b.size(), 4);
        if (rq_a.size() == 4) begin
            chk("mixed.a.d0", rq_a[0], 12'h5A5);
            chk("mixed.a.d3", rq_a[3], 12'h5A6);
        end
        if (rq_b.size() == 4) chk("mixed.b.d2", rq_b[2], 12'h5A7);

        // Reset with three posted writes and display reads in flight.
        @(negedge clk);
        ifa.disp_req = 1;
        ifa.disp_addr = 17'd50;
        for (int i = 0; i < 3; i++) cl_op(1, 17'(400 + i), 12'(12'h300 + i), w);
        @(negedge clk);
        ifa.cl_valid = 0;
        rst = 1;
        @(negedge clk);
        rst = 0;
        ifa.disp_req = 0;
        #1;
        chk("mrst.a.mem_en", ifa.mem_en, 0);
        chk("mrst.b.mem_en", ifb.mem_en, 0);
        chk("mrst.wait_max", ifa.cl_wait_max, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("mrst.no_drain", ifa.mem_en | ifb.mem_en, 0);
            chk("mrst.no_valid", ifa.disp_dvalid | ifb.disp_dvalid | ifa.cl_rvalid | ifb.cl_rvalid, 0);
        end

        repeat (3) @(negedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
